pwm_output_ctrl: RTL and testbench
==================================

Name: pwm_output_ctrl

Overview:
- Consumes the five 8-bit configuration registers written by the SPI peripheral.
- Drives 16 user outputs, each static or PWM-modulated, with one shared 8-bit duty cycle of about 3 kHz at a 10 MHz clk.
- Sits directly downstream of the SPI register block and upstream of the chip output pins.
- The duty value is double-buffered so that SPI writes never produce a truncated or glitched PWM period.

Parameters:
- PRESCALE, 13: clk cycles per PWM step; PWM period = PRESCALE*256 clk cycles, about 3.0 kHz at 10 MHz. Legal range 1..65535.
- NUM_OUT, 16: number of outputs. Fixed at 16; the parameter exists for package consistency only.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- en_out_lo  input  8  output enable bits 7:0 (SPI register address 0)
- en_out_hi  input  8  output enable bits 15:8 (address 1)
- en_pwm_lo  input  8  PWM-mode select bits 7:0 (address 2)
- en_pwm_hi  input  8  PWM-mode select bits 15:8 (address 3)
- duty  input  8  PWM duty cycle (address 4)
- out  output  16  registered output pins
- period_start  output  1  one-clk pulse at the start of each PWM period

Behaviour:
- Inputs are synchronous to clk (SPI block registers share clk). No resynchronisation is done here.
- Reset (asynchronous assert, synchronous release through flops):
  - out=16'h0000, period_start=0
  - prescale counter=0, pwm_cnt=0, duty_sh=0
- Prescaler:
  - pre_cnt counts 0..PRESCALE-1 and wraps.
  - tick=1 for the single clk where pre_cnt==PRESCALE-1.
  - PRESCALE=1 gives tick every cycle.
- PWM counter:
  - 8-bit pwm_cnt increments on tick and wraps 255->0. No other increment source.
- Duty shadow:
  - duty_sh loads from duty only on the clk where tick=1 and pwm_cnt==255, i.e. the wrap.
  - duty changes mid-period have no effect until the next period.
  - After reset, the first period uses duty_sh=0.
- Level:
  - pwm_level = 1 if duty_sh==8'hFF, else (pwm_cnt < duty_sh).
  - duty 0 gives constant low; duty 0xFF gives constant high; otherwise high for duty_sh steps of 256.
- Per-bit output, with en_out = {en_out_hi,en_out_lo} and en_pwm = {en_pwm_hi,en_pwm_lo}:
  - en_out[i]=0: out[i]=0, regardless of en_pwm[i].
  - en_out[i]=1, en_pwm[i]=0: out[i]=1.
  - en_out[i]=1, en_pwm[i]=1: out[i]=pwm_level.
- Latency:
  - out is registered: one clk after the pwm_cnt/duty_sh/enable state that produced it.
  - Enable/mode changes are not shadowed and appear at out one clk after the input changes.
- period_start:
  - Registered; high for exactly one clk, on the cycle after pwm_cnt wraps 255->0. Aligned with the first out value of the new period.
- Simultaneous events: a duty change on the same clk as the wrap is captured into duty_sh, since the shadow samples the current duty input at the wrap.
- Reset mid-period: all state clears immediately. After release, counting restarts from pwm_cnt=0, pre_cnt=0 with no partial period.
- No combinational path from inputs to out.

Decomposition:
- Shared package pwm_pkg:
  - PWM_BITS=8, NUM_OUT=16
  - PWM_PRESCALE_DEFAULT=13
  - localparams for SPI register addresses 0..4, shared with the SPI block's address decode.
- Sub-module pwm_prescaler (parameter PRESCALE; ports clk, rst_n, tick): natural reuse point for other timed blocks.
- Top module holds pwm_cnt, duty_sh, level compare, output mux/register and period_start.

Test Plan:
- Reset check: assert rst_n=0 mid-run with out toggling -> out=0 and period_start=0 immediately (asynchronous). After release, first period_start at clk 13*256.
- Static outputs: en_out=16'hA5A5, en_pwm=0, duty=8'h80 -> out==16'hA5A5 constant over 3 periods, with no PWM toggling.
- PWM duty 50%: en_out=16'hFFFF, en_pwm=16'h00FF, duty=8'h80 -> out[7:0] high for exactly 128*13=1664 clks of each 3328-clk period; out[15:8] constantly 1.
- Duty extremes: duty=8'h00 -> PWM bits constantly 0. duty=8'hFF -> PWM bits constantly 1, no single-step low glitch at the wrap.
- Shadowing: change duty 0x40->0xC0 at pwm_cnt=0x20 -> the current period stays high for 64 steps; the next period, starting at period_start, is high for 192 steps.
- Enable gating: en_out=16'h0000, en_pwm=16'hFFFF, duty=8'h80 -> out=0. Then set en_out=16'hFFFF mid-period -> out follows pwm_level one clk later.

Source files
------------

// File: rtl/pwm_output_ctrl_pkg.sv
// Shared constants for the PWM output block and the SPI register block that feeds it.
// The SPI address map lives here so both sides decode the same addresses.
package pwm_pkg;
    localparam int unsigned PWM_BITS             = 8;
    localparam int unsigned NUM_OUT              = 16;
    localparam int unsigned PWM_PRESCALE_DEFAULT = 13;

    localparam logic [2:0] ADDR_EN_OUT_LO = 3'd0;
    localparam logic [2:0] ADDR_EN_OUT_HI = 3'd1;
    localparam logic [2:0] ADDR_EN_PWM_LO = 3'd2;
    localparam logic [2:0] ADDR_EN_PWM_HI = 3'd3;
    localparam logic [2:0] ADDR_DUTY      = 3'd4;

    // Full-scale duty is forced high so 0xFF never shows a one-step low at the wrap.
    function automatic logic pwm_level_f(input logic [PWM_BITS-1:0] cnt,
                                         input logic [PWM_BITS-1:0] duty_sh);
        return (duty_sh == '1) || (cnt < duty_sh);
    endfunction
endpackage

// File: rtl/pwm_output_ctrl_if.sv
// Configuration registers handed from the SPI register block to the PWM output block.
interface pwm_output_ctrl_if;
    logic [7:0] en_out_lo;
    logic [7:0] en_out_hi;
    logic [7:0] en_pwm_lo;
    logic [7:0] en_pwm_hi;
    logic [7:0] duty;

    modport master (output en_out_lo, en_out_hi, en_pwm_lo, en_pwm_hi, duty);
    modport slave  (input  en_out_lo, en_out_hi, en_pwm_lo, en_pwm_hi, duty);
endinterface

// File: rtl/pwm_output_ctrl_prescaler.sv
// Free-running prescaler: one-cycle tick every PRESCALE clocks, counting 0..PRESCALE-1.
module pwm_prescaler #(
    parameter int unsigned PRESCALE = 13
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);
    localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] pre_cnt_q;
    logic [CW-1:0] pre_cnt_d;

    always_comb begin
        tick      = (pre_cnt_q == LAST);
        pre_cnt_d = tick ? '0 : pre_cnt_q + CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt_q <= '0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
        end
    end
endmodule

// File: rtl/pwm_output_ctrl.sv
// 16-output static/PWM driver with a double-buffered duty value; all outputs registered.
module pwm_output_ctrl
    import pwm_pkg::*;
#(
    parameter int unsigned PRESCALE = PWM_PRESCALE_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    pwm_output_ctrl_if.slave    cfg,
    output logic [NUM_OUT-1:0]  out,
    output logic                period_start
);
    logic                tick;
    logic [PWM_BITS-1:0] pwm_cnt_q,  pwm_cnt_d;
    logic [PWM_BITS-1:0] duty_sh_q,  duty_sh_d;
    logic                wrap_q,     wrap_d;
    logic [NUM_OUT-1:0]  out_q,      out_d;
    logic                period_start_q, period_start_d;
    logic [NUM_OUT-1:0]  en_out;
    logic [NUM_OUT-1:0]  en_pwm;
    logic                pwm_level;

    pwm_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    always_comb begin
        en_out    = {cfg.en_out_hi, cfg.en_out_lo};
        en_pwm    = {cfg.en_pwm_hi, cfg.en_pwm_lo};
        wrap_d    = tick && (pwm_cnt_q == '1);
        pwm_cnt_d = tick ? pwm_cnt_q + PWM_BITS'(1) : pwm_cnt_q;
        duty_sh_d = wrap_d ? cfg.duty : duty_sh_q;
        pwm_level = pwm_level_f(pwm_cnt_q, duty_sh_q);
        out_d     = en_out & (~en_pwm | {NUM_OUT{pwm_level}});
        // Delayed one extra cycle so the pulse lines up with the first out of the new period.
        period_start_d = wrap_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt_q      <= '0;
            duty_sh_q      <= '0;
            wrap_q         <= 1'b0;
            out_q          <= '0;
            period_start_q <= 1'b0;
        end else begin
            pwm_cnt_q      <= pwm_cnt_d;
            duty_sh_q      <= duty_sh_d;
            wrap_q         <= wrap_d;
            out_q          <= out_d;
            period_start_q <= period_start_d;
        end
    end

    assign out          = out_q;
    assign period_start = period_start_q;
endmodule

// File: tb/tb_pwm_output_ctrl.sv
// Self-checking bench for pwm_output_ctrl against a cycle-count based reference model.
module tb_pwm_output_ctrl;
    localparam int PRE = 13;
    localparam int PER = PRE * 256;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] pwm_out;
    logic        ps;

    int checks = 0;
    int errors = 0;

    pwm_output_ctrl_if cfg ();

    pwm_output_ctrl #(.PRESCALE(PRE)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg          (cfg.slave),
        .out          (pwm_out),
        .period_start (ps)
    );

    always #5 clk = ~clk;

    // Reference model: position in the period is derived from edges since reset release.
    int          n;
    logic [7:0]  m_dsh;
    logic [15:0] exp_out;
    logic        exp_ps;
    int          m_step;
    logic        m_lvl;
    logic [15:0] m_en, m_pwm;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n = 0; m_dsh = 8'h00; exp_out = 16'h0000; exp_ps = 1'b0;
        end else begin
            m_step = (n / PRE) % 256;
            m_lvl  = (m_dsh == 8'hFF) || (m_step < int'(m_dsh));
            m_en   = {cfg.en_out_hi, cfg.en_out_lo};
            m_pwm  = {cfg.en_pwm_hi, cfg.en_pwm_lo};
            for (int i = 0; i < 16; i++)
                exp_out[i] = !m_en[i] ? 1'b0 : (!m_pwm[i] ? 1'b1 : m_lvl);
            exp_ps = (n > 0) && (n % PER == 0);
            if (n % PER == PER - 1) m_dsh = cfg.duty;
            n++;
        end
    end

    task automatic set_cfg(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] d);
        cfg.en_out_lo = eo[7:0];  cfg.en_out_hi = eo[15:8];
        cfg.en_pwm_lo = ep[7:0];  cfg.en_pwm_hi = ep[15:8];
        cfg.duty      = d;
    endtask

    task automatic wait_ps(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 2 * PER; k++) begin
            @(negedge clk);
            if (ps === 1'b1) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        int c;
        set_cfg(16'h0000, 16'h0000, 8'h00);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (pwm_out !== 16'h0000 || ps !== 1'b0)
            begin errors++; $display("FAIL reset_init out=%h ps=%b want 0000/0", pwm_out, ps); end
        rst_n = 1'b1;
        set_cfg(16'hFFFF, 16'hFFFF, 8'h80);
        repeat (PER + PER / 2) begin
            @(negedge clk);
            checks++;
            if (pwm_out !== exp_out || ps !== exp_ps) begin
                errors++;
                $display("FAIL reset_run out=%h ps=%b want %h/%b", pwm_out, ps, exp_out, exp_ps);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (pwm_out !== 16'h0000 || ps !== 1'b0)
            begin errors++; $display("FAIL reset_async out=%h ps=%b want 0000/0", pwm_out, ps); end
        @(negedge clk);
        rst_n = 1'b1;
        c = 0;
        while (ps !== 1'b1 && c < 2 * PER) begin
            @(negedge clk);
            c++;
            checks++;
            if (pwm_out !== exp_out || ps !== exp_ps) begin
                errors++;
                $display("FAIL reset_restart out=%h ps=%b want %h/%b", pwm_out, ps, exp_out, exp_ps);
            end
        end
        checks++;
        if (c != PER + 1)
            begin errors++; $display("FAIL reset_first_ps edge=%0d want %0d", c, PER + 1); end
    endtask

    task automatic test_static();
        set_cfg(16'hA5A5, 16'h0000, 8'h80);
        @(negedge clk);
        repeat (3 * PER) begin
            @(negedge clk);
            checks++;
            if (pwm_out !== 16'hA5A5 || pwm_out !== exp_out)
                begin errors++; $display("FAIL static out=%h want a5a5 (model %h)", pwm_out, exp_out); end
        end
    endtask

    task automatic test_pwm50();
        bit ok;
        int hi;
        set_cfg(16'hFFFF, 16'h00FF, 8'h80);
        wait_ps(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL pwm50_wait ps=%b want 1", ps); end
        for (int p = 0; p < 3; p++) begin
            hi = 0;
            for (int i = 0; i < PER; i++) begin
                if (i > 0) @(negedge clk);
                hi += int'(pwm_out[0]);
                checks++;
                if (pwm_out !== exp_out || pwm_out[15:8] !== 8'hFF || ps !== exp_ps)
                    begin errors++; $display("FAIL pwm50_cycle out=%h ps=%b want %h/%b", pwm_out, ps, exp_out, exp_ps); end
            end
            @(negedge clk);
            checks++;
            if (hi != 128 * PRE)
                begin errors++; $display("FAIL pwm50_high got=%0d want %0d", hi, 128 * PRE); end
        end
    endtask

    task automatic test_extremes();
        bit ok;
        set_cfg(16'hFFFF, 16'hFFFF, 8'h00);
        wait_ps(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL ext0_wait ps=%b want 1", ps); end
        repeat (PER + 20) begin
            checks++;
            if (pwm_out !== 16'h0000 || pwm_out !== exp_out)
                begin errors++; $display("FAIL duty00 out=%h want 0000", pwm_out); end
            @(negedge clk);
        end
        cfg.duty = 8'hFF;
        wait_ps(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL extff_wait ps=%b want 1", ps); end
        repeat (PER + 20) begin
            checks++;
            if (pwm_out !== 16'hFFFF || pwm_out !== exp_out)
                begin errors++; $display("FAIL dutyff out=%h want ffff", pwm_out); end
            @(negedge clk);
        end
    endtask

    task automatic test_shadow();
        bit ok;
        int hi;
        set_cfg(16'hFFFF, 16'h00FF, 8'h40);
        wait_ps(ok);
        wait_ps(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL shadow_wait ps=%b want 1", ps); end
        for (int p = 0; p < 2; p++) begin
            hi = 0;
            for (int i = 0; i < PER; i++) begin
                hi += int'(pwm_out[0]);
                checks++;
                if (pwm_out !== exp_out || ps !== exp_ps)
                    begin errors++; $display("FAIL shadow_cycle out=%h ps=%b want %h/%b", pwm_out, ps, exp_out, exp_ps); end
                if (p == 0 && i == 32 * PRE) cfg.duty = 8'hC0;
                @(negedge clk);
            end
            checks++;
            if (hi != (p == 0 ? 64 : 192) * PRE)
                begin errors++; $display("FAIL shadow_high period=%0d got=%0d want %0d", p, hi, (p == 0 ? 64 : 192) * PRE); end
            checks++;
            if (ps !== 1'b1) begin errors++; $display("FAIL shadow_ps ps=%b want 1", ps); end
        end
    endtask

    task automatic test_gating();
        set_cfg(16'h0000, 16'hFFFF, 8'h80);
        repeat (50) begin
            @(negedge clk);
            checks++;
            if (pwm_out !== 16'h0000)
                begin errors++; $display("FAIL gate_off out=%h want 0000", pwm_out); end
        end
        cfg.en_out_lo = 8'hFF; cfg.en_out_hi = 8'hFF;
        checks++;
        if (pwm_out !== 16'h0000)
            begin errors++; $display("FAIL gate_latency out=%h want 0000", pwm_out); end
        repeat (200) begin
            @(negedge clk);
            checks++;
            if (pwm_out !== exp_out || (pwm_out !== 16'h0000 && pwm_out !== 16'hFFFF))
                begin errors++; $display("FAIL gate_on out=%h want %h", pwm_out, exp_out); end
        end
    endtask

    task automatic test_simultaneous();
        logic [7:0] d;
        int hi, k;
        set_cfg(16'hFFFF, 16'hFFFF, 8'h11);
        k = 0;
        while (n % PER != PER - 1 && k < 2 * PER) begin @(negedge clk); k++; end
        d = 8'($urandom_range(1, 254));
        cfg.duty = d;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (ps !== 1'b1) begin errors++; $display("FAIL simul_ps ps=%b want 1", ps); end
        cfg.duty = 8'h11;
        hi = 0;
        for (int i = 0; i < PER; i++) begin
            hi += int'(pwm_out[3]);
            checks++;
            if (pwm_out !== exp_out)
                begin errors++; $display("FAIL simul_cycle out=%h want %h", pwm_out, exp_out); end
            @(negedge clk);
        end
        checks++;
        if (hi != int'(d) * PRE)
            begin errors++; $display("FAIL simul_high got=%0d want %0d", hi, int'(d) * PRE); end
    endtask

    task automatic test_random();
        int len;
        for (int it = 0; it < 8; it++) begin
            set_cfg(16'($urandom), 16'($urandom), 8'($urandom));
            len = $urandom_range(200, 2500);
            repeat (len) begin
                @(negedge clk);
                if ($urandom_range(0, 99) == 0) cfg.duty = 8'($urandom);
                checks++;
                if (pwm_out !== exp_out || ps !== exp_ps)
                    begin errors++; $display("FAIL random_%0d out=%h ps=%b want %h/%b", it, pwm_out, ps, exp_out, exp_ps); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_static();
        test_pwm50();
        test_extremes();
        test_shadow();
        test_gating();
        test_simultaneous();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
